mem_arb: RTL and testbench

//  Parametrised N-channel arbiter sharing one single-port SRAM between core memory masters
//  (instruction fetch, LSU, debug/DMA). One request is granted per cycle, by round-robin or

---
 rtl/mem_arb.sv | 173 +++++++++++++++++
 tb/tb_mem_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
//   Shares one single-port SRAM between NCH memory masters (instruction fetch,
//   LSU, debug/DMA). It grants one request per cycle, using either round-robin
//   or fixed priority. A read-tag pipeline follows each read through the SRAM
//   latency so that the returning data is flagged for the channel that issued
//   the read.
//
// Parameters
//   NCH     number of request channels (2..8)
//   AW      address width
//   DW      data width (multiple of 8); strobe width SW = DW/8
//   RD_LAT  SRAM read latency in cycles (1..4)
//   MODE    0 = round-robin, 1 = fixed priority (channel 0 highest)
//
// Ports
//   clk      in   1        clock
//   rst      in   1        synchronous reset, active-high
//   req_vld  in   NCH      channel c has a request this cycle
//   req_rdy  out  NCH      one-hot grant (combinational)
//   req_a    in   NCH*AW   per-channel address, channel c at [c*AW +: AW]
//   req_we   in   NCH*SW   per-channel byte write strobes
//   req_wd   in   NCH*DW   per-channel write data
//   req_re   in   NCH*SW   per-channel byte read strobes
//   rsp_vld  out  NCH      one-hot: rsp_rd carries read data for channel c
//   rsp_rd   out  DW       read data (shared bus, straight from mem_rd)
//   mem_a    out  AW       SRAM address
//   mem_we   out  SW       SRAM byte write enables
//   mem_wd   out  DW       SRAM write data
//   mem_re   out  SW       SRAM byte read enables
//   mem_rd   in   DW       SRAM read data, valid RD_LAT cycles after mem_re
// -----------------------------------------------------------------------------
module mem_arb #(
  parameter int NCH    = 2,
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_vld,
  output logic [NCH-1:0]          req_rdy,
  input  logic [NCH*AW-1:0]       req_a,
  input  logic [NCH*(DW/8)-1:0]   req_we,
  input  logic [NCH*DW-1:0]       req_wd,
  input  logic [NCH*(DW/8)-1:0]   req_re,
  output logic [NCH-1:0]          rsp_vld,
  output logic [DW-1:0]           rsp_rd,
  output logic [AW-1:0]           mem_a,
  output logic [DW/8-1:0]         mem_we,
  output logic [DW-1:0]           mem_wd,
  output logic [DW/8-1:0]         mem_re,
  input  logic [DW-1:0]           mem_rd
);

  localparam int SW = DW / 8;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  // Channel id to one-hot channel vector.
  function automatic logic [NCH-1:0] onehot(input logic [PW-1:0] id);
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      if (id == PW'(c)) v[c] = 1'b1;
    end
    return v;
  endfunction

  // Round-robin start channel: the channel after the last one granted.
  logic [PW-1:0]  ptr;

  logic           gnt_any;
  logic [PW-1:0]  gnt_id;
  logic [NCH-1:0] gnt_oh;

  logic [SW-1:0]  sel_we;
  logic [SW-1:0]  sel_re;
  logic [AW-1:0]  sel_a;
  logic [DW-1:0]  sel_wd;
  logic           is_wr;
  logic           rd_acc;

  // Read-tag pipeline: valid is control (reset), channel id is data (not reset).
  logic [RD_LAT-1:0] tag_vld_p;
  logic [PW-1:0]     tag_id_p [RD_LAT];

  // ---------------------------------------------------------------------------
  // Grant (combinational). Only req_vld and ptr are looked at, so the strobes
  // can never close a combinational loop back onto req_rdy.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [PW:0] idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      // Walk the channels in priority order; in round-robin mode the walk
      // starts at ptr and wraps from NCH-1 back to 0.
      if (MODE == 0) idx = {1'b0, ptr} + (PW+1)'(k);
      else           idx = (PW+1)'(k);
      if (idx >= (PW+1)'(NCH)) idx = idx - (PW+1)'(NCH);
      if (!gnt_any && req_vld[idx[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[PW-1:0];
      end
    end
  end

  assign gnt_oh  = gnt_any ? onehot(gnt_id) : '0;
  assign req_rdy = gnt_oh;

  // ---------------------------------------------------------------------------
  // Memory drive (combinational from the granted channel). With no grant,
  // gnt_id sits at 0, so address and write data show channel 0, and both
  // enables are held low.
  // ---------------------------------------------------------------------------
  assign sel_we = req_we[gnt_id*SW +: SW];
  assign sel_re = req_re[gnt_id*SW +: SW];
  assign sel_a  = req_a [gnt_id*AW +: AW];
  assign sel_wd = req_wd[gnt_id*DW +: DW];

  // Any write strobe makes the access a write; its read strobes are dropped.
  assign is_wr  = |sel_we;
  assign rd_acc = gnt_any && !is_wr && (|sel_re);

  assign mem_a  = sel_a;
  assign mem_wd = sel_wd;
  assign mem_we = gnt_any ? sel_we : '0;
  assign mem_re = (gnt_any && !is_wr) ? sel_re : '0;

  // ---------------------------------------------------------------------------
  // Round-robin pointer. Every accepted request advances it, including nops.
  // In fixed-priority mode it is kept up to date but never looked at.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == PW'(NCH-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0 .. RD_LAT-1: read tags. The pipeline shifts every cycle, in step
  // with the SRAM's fixed latency, so it needs no stall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= rd_acc;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_id_p[0] <= gnt_id;
    for (int s = 1; s < RD_LAT; s++) begin
      tag_id_p[s] <= tag_id_p[s-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Response: the last tag stage lines up with mem_rd. The read data itself
  // passes through unregistered.
  // ---------------------------------------------------------------------------
  assign rsp_vld = tag_vld_p[RD_LAT-1] ? onehot(tag_id_p[RD_LAT-1]) : '0;
  assign rsp_rd  = mem_rd;

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb
//   Drives two arbiter configurations from one shared stimulus stream:
//     u_rr : NCH=3, MODE=0 (round-robin),     RD_LAT=2
//     u_fp : NCH=4, MODE=1 (fixed priority),  RD_LAT=3
//   Each instance is attached to its own behavioural SRAM. A reference model
//   predicts the grant, the memory drive and the response stream. It keeps a
//   plain memory array and a queue of pending responses, each tagged with the
//   cycle in which it falls due.
// -----------------------------------------------------------------------------
module tb_mem_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus, up to 4 channels.
  logic [3:0]  s_vld;
  logic [15:0] s_a  [4];
  logic [3:0]  s_we [4];
  logic [3:0]  s_re [4];
  logic [31:0] s_wd [4];

  // ---- instance A: round-robin, 3 channels, latency 2
  logic [2:0]  a_req_vld, a_req_rdy, a_rsp_vld;
  logic [47:0] a_req_a;
  logic [11:0] a_req_we, a_req_re;
  logic [95:0] a_req_wd;
  logic [31:0] a_rsp_rd, a_mem_wd, a_mem_rd;
  logic [15:0] a_mem_a;
  logic [3:0]  a_mem_we, a_mem_re;

  // ---- instance B: fixed priority, 4 channels, latency 3
  logic [3:0]   b_req_vld, b_req_rdy, b_rsp_vld;
  logic [63:0]  b_req_a;
  logic [15:0]  b_req_we, b_req_re;
  logic [127:0] b_req_wd;
  logic [31:0]  b_rsp_rd, b_mem_wd, b_mem_rd;
  logic [15:0]  b_mem_a;
  logic [3:0]   b_mem_we, b_mem_re;

  always_comb begin
    a_req_vld = s_vld[2:0];
    a_req_a   = {s_a[2],  s_a[1],  s_a[0]};
    a_req_we  = {s_we[2], s_we[1], s_we[0]};
    a_req_re  = {s_re[2], s_re[1], s_re[0]};
    a_req_wd  = {s_wd[2], s_wd[1], s_wd[0]};
    b_req_vld = s_vld;
    b_req_a   = {s_a[3],  s_a[2],  s_a[1],  s_a[0]};
    b_req_we  = {s_we[3], s_we[2], s_we[1], s_we[0]};
    b_req_re  = {s_re[3], s_re[2], s_re[1], s_re[0]};
    b_req_wd  = {s_wd[3], s_wd[2], s_wd[1], s_wd[0]};
  end

  mem_arb #(.NCH(3), .AW(16), .DW(32), .RD_LAT(2), .MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .req_vld(a_req_vld), .req_rdy(a_req_rdy),
    .req_a(a_req_a), .req_we(a_req_we), .req_wd(a_req_wd), .req_re(a_req_re),
    .rsp_vld(a_rsp_vld), .rsp_rd(a_rsp_rd),
    .mem_a(a_mem_a), .mem_we(a_mem_we), .mem_wd(a_mem_wd), .mem_re(a_mem_re),
    .mem_rd(a_mem_rd)
  );

  mem_arb #(.NCH(4), .AW(16), .DW(32), .RD_LAT(3), .MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .req_vld(b_req_vld), .req_rdy(b_req_rdy),
    .req_a(b_req_a), .req_we(b_req_we), .req_wd(b_req_wd), .req_re(b_req_re),
    .rsp_vld(b_rsp_vld), .rsp_rd(b_rsp_rd),
    .mem_a(b_mem_a), .mem_we(b_mem_we), .mem_wd(b_mem_wd), .mem_re(b_mem_re),
    .mem_rd(b_mem_rd)
  );

  // ---- behavioural SRAMs (32 words each, read data delayed by the latency)
  logic [31:0] sram_a [32];
  logic [31:0] sram_b [32];
  logic [31:0] dl_a [2];
  logic [31:0] dl_b [3];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (a_mem_we[b]) sram_a[a_mem_a[4:0]][8*b +: 8] <= a_mem_wd[8*b +: 8];
      if (b_mem_we[b]) sram_b[b_mem_a[4:0]][8*b +: 8] <= b_mem_wd[8*b +: 8];
    end
    dl_a[0] <= (a_mem_re != 4'h0) ? sram_a[a_mem_a[4:0]] : 32'h0;
    dl_a[1] <= dl_a[0];
    dl_b[0] <= (b_mem_re != 4'h0) ? sram_b[b_mem_a[4:0]] : 32'h0;
    dl_b[1] <= dl_b[0];
    dl_b[2] <= dl_b[1];
  end
  assign a_mem_rd = dl_a[1];
  assign b_mem_rd = dl_b[2];

  // ---- observed outputs, gathered per instance
  logic [3:0]  o_rdy [2];
  logic [3:0]  o_we  [2];
  logic [3:0]  o_re  [2];
  logic [3:0]  o_rv  [2];
  logic [15:0] o_a   [2];
  logic [31:0] o_wd  [2];
  logic [31:0] o_rd  [2];
  assign o_rdy[0] = {1'b0, a_req_rdy};
  assign o_rdy[1] = b_req_rdy;
  assign o_rv[0]  = {1'b0, a_rsp_vld};
  assign o_rv[1]  = b_rsp_vld;
  assign o_we[0]  = a_mem_we;
  assign o_we[1]  = b_mem_we;
  assign o_re[0]  = a_mem_re;
  assign o_re[1]  = b_mem_re;
  assign o_a[0]   = a_mem_a;
  assign o_a[1]   = b_mem_a;
  assign o_wd[0]  = a_mem_wd;
  assign o_wd[1]  = b_mem_wd;
  assign o_rd[0]  = a_rsp_rd;
  assign o_rd[1]  = b_rsp_rd;

  // ---- checking
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
  endtask

  // ---- reference model
  typedef struct {
    int          due;
    int          ch;
    logic [31:0] d;
  } rsp_t;

  rsp_t        rq [2][$];
  logic [31:0] mm [2][32];
  int          ptr_m [2];
  int          cyc = 0;

  task automatic model_step(input int i);
    int n, lat, g, c;
    logic [3:0]  e_rdy, e_we, e_re, e_rv;
    logic [15:0] e_a;
    logic [31:0] e_wd, e_rd;
    rsp_t        r;
    n   = (i == 0) ? 3 : 4;
    lat = (i == 0) ? 2 : 3;

    // Which channel wins: the first requester in priority order.
    g = -1;
    for (int k = 0; k < n; k++) begin
      c = (i == 1) ? k : (ptr_m[i] + k) % n;
      if (g < 0 && s_vld[c]) g = c;
    end

    e_rdy = (g < 0) ? 4'h0 : 4'(1 << g);
    e_a   = (g < 0) ? s_a[0]  : s_a[g];
    e_wd  = (g < 0) ? s_wd[0] : s_wd[g];
    e_we  = (g < 0) ? 4'h0 : s_we[g];
    e_re  = (g < 0 || s_we[g] != 4'h0) ? 4'h0 : s_re[g];

    e_rv = 4'h0;
    e_rd = 32'h0;
    if (rq[i].size() > 0 && rq[i][0].due == cyc) begin
      r    = rq[i].pop_front();
      e_rv = 4'(1 << r.ch);
      e_rd = r.d;
    end

    check($sformatf("u%0d.req_rdy", i), 64'(o_rdy[i]), 64'(e_rdy));
    check($sformatf("u%0d.mem_we",  i), 64'(o_we[i]),  64'(e_we));
    check($sformatf("u%0d.mem_re",  i), 64'(o_re[i]),  64'(e_re));
    check($sformatf("u%0d.mem_a",   i), 64'(o_a[i]),   64'(e_a));
    check($sformatf("u%0d.mem_wd",  i), 64'(o_wd[i]),  64'(e_wd));
    check($sformatf("u%0d.rsp_vld", i), 64'(o_rv[i]),  64'(e_rv));
    if (e_rv != 4'h0) check($sformatf("u%0d.rsp_rd", i), 64'(o_rd[i]), 64'(e_rd));

    // Commit the accepted request.
    if (g >= 0) begin
      if (s_we[g] != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (s_we[g][b]) mm[i][s_a[g][4:0]][8*b +: 8] = s_wd[g][8*b +: 8];
      end else if (s_re[g] != 4'h0 && !rst) begin
        r.due = cyc + lat;
        r.ch  = g;
        r.d   = mm[i][s_a[g][4:0]];
        rq[i].push_back(r);
      end
      ptr_m[i] = (g == n - 1) ? 0 : g + 1;
    end
    if (rst) begin
      ptr_m[i] = 0;
      rq[i].delete();
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
    cyc++;
  end

  // ---- stimulus helpers
  task automatic idle();
    s_vld = 4'h0;
    for (int c = 0; c < 4; c++) begin
      s_a[c] = 16'h0; s_we[c] = 4'h0; s_re[c] = 4'h0; s_wd[c] = 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int c, input logic [15:0] a);
    s_vld[c] = 1'b1; s_a[c] = a; s_re[c] = 4'hF; s_we[c] = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ptr_m[i] = 0;
      for (int w = 0; w < 32; w++) mm[i][w] = 32'h0;
    end
    for (int w = 0; w < 32; w++) begin
      sram_a[w] = 32'h0;
      sram_b[w] = 32'h0;
    end
    rst = 1'b1;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // All channels reading together: A rotates through 0,1,2; B stays on ch0.
    for (int k = 0; k < 6; k++) begin
      idle();
      for (int c = 0; c < 4; c++) rd(c, 16'(c + 4));
      tick();
    end

    // A write followed by a read of the same word; only the read answers.
    idle();
    s_vld[1] = 1'b1; s_a[1] = 16'h0010; s_we[1] = 4'hF; s_wd[1] = 32'hDEADBEEF;
    tick();
    idle(); rd(0, 16'h0010);
    tick();
    idle();
    repeat (4) tick();

    // Pointer wrap: ch1 alone, then ch0 alone, then a nop from ch2.
    idle(); rd(1, 16'h0003); tick();
    idle(); rd(0, 16'h0003); tick();
    idle(); s_vld[2] = 1'b1; s_a[2] = 16'h0007; tick();
    idle(); repeat (3) tick();

    // Requests on 1110, then on 1111.
    idle(); for (int c = 1; c < 4; c++) rd(c, 16'(c)); tick(); tick();
    idle(); for (int c = 0; c < 4; c++) rd(c, 16'(c)); repeat (3) tick();
    idle(); repeat (4) tick();

    // Reset while two reads are still in flight.
    idle(); rd(0, 16'h0010); tick();
    idle(); rd(1, 16'h0004); tick();
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    idle(); for (int c = 0; c < 4; c++) rd(c, 16'h0010); tick();
    idle(); repeat (4) tick();

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      rst   = ($urandom_range(0, 79) == 0);
      s_vld = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        s_a[c]  = 16'($urandom_range(0, 31));
        s_wd[c] = $urandom;
        s_we[c] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        s_re[c] = 4'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (5) tick();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
